hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the 5-stage MIPS pipeline. Reads the fields that ID/EX and EX/MEM present to EX and MEM.
//  Drives the write-enable and bubble/flush controls back into PC, IF/ID, ID/EX and EX/MEM.
//  Registered FSM (RUN/STALL) with a stall down-counter, plus saturating stall and flush performance counters.
// PARAMETERS
//  REG_ADDR_W  5   register-specifier width
//  CNT_W       16  width of stallCount / flushCount (saturating)
// PORTS
//  clock        in   1           rising-edge clock
//  reset        in   1           synchronous, active-low reset
//  idRs         in   REG_ADDR_W  rs of instruction held in IF/ID
//  idRt         in   REG_ADDR_W  rt of instruction held in IF/ID
//  idUsesRt     in   1           IF/ID instruction reads rt (R-type, beq, sw)
//  exMemRead    in   1           ID/EX memRead output (load in EX)
//  exRegWrite   in   1           ID/EX regWrite output
//  exDestReg    in   REG_ADDR_W  EX destination (rd or rt per regDest)
//  memRegWrite  in   1           EX/MEM regWrite
//  memDestReg   in   REG_ADDR_W  EX/MEM destination register
//  branchTaken  in   1           branch resolved taken in MEM this cycle
//  pcWrite      out  1           PC load enable
//  ifIdWrite    out  1           IF/ID load enable
//  ifIdFlush    out  1           IF/ID loads zero (nop)
//  idExBubble   out  1           ID/EX loads all control bits as 0
//  exMemFlush   out  1           EX/MEM loads all control bits as 0
//  stallCount   out  CNT_W       stall cycles since reset
//  flushCount   out  CNT_W       taken-branch flushes since reset
// BEHAVIOUR
//  match(r) = (r != 0) && (r == idRs || (idUsesRt && r == idRt)). Register $0 never causes a hazard.
//  Control outputs are Mealy outputs: a combinational function of the state register and current inputs.
//  State, stallLeft and the counters update on the rising edge.
//  Reset (reset==0 sampled at an edge): state=RUN, stallLeft=0, counters=0.
//    While reset==0: pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExBubble=1, exMemFlush=1.
//  Default (RUN, no event): pcWrite=1, ifIdWrite=1, all flush/bubble outputs=0.
//  Hazard detected in RUN, cycle N (needStall=k>0):
//    pcWrite=0, ifIdWrite=0, idExBubble=1 in cycle N.
//    If k>1: go to STALL with stallLeft=k-1; else stay in RUN.
//  STALL: same outputs as the hazard cycle. stallLeft decrements each cycle; return to RUN when it reaches 1.
//    Inputs are not re-compared while in STALL.
//  branchTaken has priority over any stall, in RUN and in STALL:
//    ifIdFlush=1, idExBubble=1, exMemFlush=1, pcWrite=1 (load target), ifIdWrite=1.
//    Next state is RUN and stallLeft=0, so a pending stall is aborted.
//  Counters:
//    stallCount +1 every cycle with pcWrite==0 and reset==1.
//    flushCount +1 per branchTaken cycle.
//    Both saturate at all-ones with no wrap.
// CONFIGURATION
//  HAZARD_FORWARD_EN defined (forwarding unit present):
//    needStall = 1 if exMemRead && match(exDestReg), else 0.
//  HAZARD_FORWARD_EN undefined (no forwarding; register file writes in first half of cycle):
//    needStall = 2 if exRegWrite && match(exDestReg).
//    Otherwise needStall = 1 if memRegWrite && match(memDestReg).
//    Otherwise needStall = 0.
// TESTING
//  T1 (FWD_EN) lw in EX (exMemRead=1, exDestReg=8), idRs=8 -> 1 cycle pcWrite=0, idExBubble=1, then RUN; stallCount=1.
//  T2 (FWD_EN) add in EX (exRegWrite=1, exMemRead=0, exDestReg=8), idRs=8 -> no stall, pcWrite=1.
//  T3 (no FWD) exRegWrite=1, exDestReg=9, idRt=9, idUsesRt=1 -> pcWrite=0 for 2 consecutive cycles; stallCount=2.
//  T4 exDestReg=0 with exMemRead=1 and idRs=0 -> no stall.
//  T5 (no FWD) enter STALL, branchTaken=1 in 2nd stall cycle -> all three flushes=1, pcWrite=1 that cycle; RUN next; flushCount=1.
//  T6 reset=0 during STALL -> next cycle state RUN, counters 0; flush/bubble=1, pcWrite=0 while held low.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the MIPS pipeline datapath and the hazard/stall controller.
//   master : pipeline side, presents ID/EX/MEM fields and consumes controls
//   slave  : hazard_ctrl side
// Signals
//   idRs, idRt, idUsesRt        - source operands of the instruction in IF/ID
//   exMemRead, exRegWrite,
//   exDestReg                   - instruction currently in EX (ID/EX outputs)
//   memRegWrite, memDestReg     - instruction currently in MEM (EX/MEM outputs)
//   branchTaken                 - branch resolved taken in MEM this cycle
//   pcWrite, ifIdWrite          - load enables for PC and IF/ID
//   ifIdFlush, idExBubble,
//   exMemFlush                  - zero the control bits of the named register
//   stallCount, flushCount      - saturating performance counters
// There is no valid/ready handshake: every field is meaningful every cycle and
// the controls are consumed on the same rising edge they are presented for.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] idRs;
  logic [REG_ADDR_W-1:0] idRt;
  logic                  idUsesRt;
  logic                  exMemRead;
  logic                  exRegWrite;
  logic [REG_ADDR_W-1:0] exDestReg;
  logic                  memRegWrite;
  logic [REG_ADDR_W-1:0] memDestReg;
  logic                  branchTaken;
  logic                  pcWrite;
  logic                  ifIdWrite;
  logic                  ifIdFlush;
  logic                  idExBubble;
  logic                  exMemFlush;
  logic [CNT_W-1:0]      stallCount;
  logic [CNT_W-1:0]      flushCount;

  modport master (
    output idRs, idRt, idUsesRt, exMemRead, exRegWrite, exDestReg,
           memRegWrite, memDestReg, branchTaken,
    input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemFlush,
           stallCount, flushCount
  );

  modport slave (
    input  idRs, idRt, idUsesRt, exMemRead, exRegWrite, exDestReg,
           memRegWrite, memDestReg, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemFlush,
           stallCount, flushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard/stall controller for a 5-stage MIPS pipeline. Compares the sources
//   of the IF/ID instruction with the destinations in EX and MEM, stalls the
//   front of the pipeline for the required number of cycles, and flushes the
//   younger stages when a branch resolves taken in MEM.
//   Configuration macro: HAZARD_FORWARD_EN
//     defined   - forwarding unit present, only load-use stalls (1 cycle)
//     undefined - no forwarding, EX producer stalls 2 cycles, MEM producer 1
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low
//   hz             hazard_ctrl_if.slave (pipeline fields in, controls out)
//   dbg_state      FSM state, 0 = RUN, 1 = STALL
//   dbg_stall_left remaining stall cycles held in the STALL state
// Controls are Mealy: combinational in the state register and current inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave hz,
  output logic         dbg_state,
  output logic [1:0]   dbg_stall_left
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t           state, state_next;
  logic [1:0]       stall_left, stall_left_next;
  logic [1:0]       need_stall;
  logic [CNT_W-1:0] stall_count, flush_count;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush;

  // $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic match(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time.
  always_comb begin
    need_stall = 2'd0;
    if (hz.exMemRead && match(hz.exDestReg, hz.idRs, hz.idRt, hz.idUsesRt))
      need_stall = 2'd1;
  end

  logic unused_nofwd;
  assign unused_nofwd = ^{hz.exRegWrite, hz.memRegWrite, hz.memDestReg};
`else
  // Without forwarding the value is usable once it reaches WB (register file
  // writes in the first half of the cycle), so EX needs 2 bubbles, MEM needs 1.
  always_comb begin
    need_stall = 2'd0;
    if (hz.exRegWrite && match(hz.exDestReg, hz.idRs, hz.idRt, hz.idUsesRt))
      need_stall = 2'd2;
    else if (hz.memRegWrite && match(hz.memDestReg, hz.idRs, hz.idRt, hz.idUsesRt))
      need_stall = 2'd1;
  end

  logic unused_fwd;
  assign unused_fwd = hz.exMemRead;
`endif

  // Next state and Mealy controls. Priority: reset, taken branch, stall.
  always_comb begin
    state_next      = state;
    stall_left_next = stall_left;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    ex_mem_flush    = 1'b0;
    if (!reset) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_bubble    = 1'b1;
      ex_mem_flush    = 1'b1;
      state_next      = RUN;
      stall_left_next = 2'd0;
    end else if (hz.branchTaken) begin
      // Load the branch target and squash the three younger instructions;
      // any stall in progress belonged to a squashed instruction.
      if_id_flush     = 1'b1;
      id_ex_bubble    = 1'b1;
      ex_mem_flush    = 1'b1;
      state_next      = RUN;
      stall_left_next = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need_stall != 2'd0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (need_stall > 2'd1) begin
              state_next      = STALL;
              stall_left_next = need_stall - 2'd1;
            end
          end
        end
        STALL: begin
          // The hazard cycle already decided the length; inputs are ignored.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (stall_left <= 2'd1) begin
            state_next      = RUN;
            stall_left_next = 2'd0;
          end else begin
            stall_left_next = stall_left - 2'd1;
          end
        end
        default: begin
          state_next      = RUN;
          stall_left_next = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= RUN;
      stall_left  <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state      <= state_next;
      stall_left <= stall_left_next;
      if (!pc_write && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (hz.branchTaken && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign hz.pcWrite     = pc_write;
  assign hz.ifIdWrite   = if_id_write;
  assign hz.ifIdFlush   = if_id_flush;
  assign hz.idExBubble  = id_ex_bubble;
  assign hz.exMemFlush  = ex_mem_flush;
  assign hz.stallCount  = stall_count;
  assign hz.flushCount  = flush_count;
  assign dbg_state      = state;
  assign dbg_stall_left = stall_left;

endmodule
